// File: rtl/sram_burst_controller.sv
// sram_burst_controller
// Serves one pipeline memory request as a burst of BURST_LEN consecutive
// SRAM words, holding ready low until the whole line has been transferred.
// Each word access takes WAIT_CYCLES clocks; on writes the last cycle of a
// beat releases WE_N while still driving data, giving the SRAM a hold time.
// Optional feature macro: SRAM_CRIT_WORD_FIRST_EN -- when defined, a burst
// starts at the requested word within the line and wraps around, so the
// critical word is transferred first.

module sram_burst_controller #(
   parameter int          DATA_W      = 32,
   parameter int          SRAM_ADDR_W = 17,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 5,
   parameter int          BURST_LEN   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          read_en,
   input  logic                          write_en,
   input  logic [31:0]                   address,
   input  logic [BURST_LEN*DATA_W-1:0]   writeData,
   output logic [BURST_LEN*DATA_W-1:0]   readData,
   output logic                          ready,
   inout  wire  [DATA_W-1:0]             SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0]        SRAM_ADDR,
   output logic                          SRAM_UB_N,
   output logic                          SRAM_LB_N,
   output logic                          SRAM_CE_N,
   output logic                          SRAM_OE_N,
   output logic                          SRAM_WE_N
);

   localparam int BYTE_SH = $clog2(DATA_W / 8);
   localparam int OFF_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int CYC_W   = $clog2(WAIT_CYCLES);

   localparam logic [CYC_W-1:0]       CYC_LAST  = CYC_W'(WAIT_CYCLES - 1);
   localparam logic [OFF_W-1:0]       BEAT_LAST = OFF_W'(BURST_LEN - 1);
   localparam logic [OFF_W-1:0]       IDX_MASK  = OFF_W'(BURST_LEN - 1);
   localparam logic [SRAM_ADDR_W-1:0] LINE_MASK = ~SRAM_ADDR_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [CYC_W-1:0]              cyc_q, cyc_d;
   logic [OFF_W-1:0]              beat_q, beat_d;
   logic [SRAM_ADDR_W-1:0]        line_base_q, line_base_d;
   logic [BURST_LEN*DATA_W-1:0]   wdata_q, wdata_d;
   logic [BURST_LEN*DATA_W-1:0]   rdata_q, rdata_d;
   logic [OFF_W-1:0]              off_q, off_d;

   logic [31:0]             byte_off;
   logic [SRAM_ADDR_W-1:0]  word_addr;
   logic [OFF_W-1:0]        word_idx;
   logic                    busy;

   // Byte address to SRAM word address; wraps modulo the SRAM size.
   assign byte_off  = address - BASE_ADDR;
   assign word_addr = SRAM_ADDR_W'(byte_off >> BYTE_SH);

   // Word of the line handled by the current beat.
   assign word_idx = (beat_q + off_q) & IDX_MASK;
   assign busy     = (state_q == S_READ) || (state_q == S_WRITE);

   // Chip is permanently selected with both byte lanes enabled.
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

   assign SRAM_ADDR = busy ? (line_base_q + SRAM_ADDR_W'(word_idx)) : word_addr;
   assign SRAM_WE_N = !((state_q == S_WRITE) && (cyc_q != CYC_LAST));
   assign SRAM_DQ   = (state_q == S_WRITE) ? wdata_q[word_idx*DATA_W +: DATA_W]
                                           : {DATA_W{1'bz}};
   assign readData  = rdata_q;

   // State, counters and latched request registers.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values of the previous cycle regardless of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         beat_q      <= '0;
         line_base_q <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         off_q       <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         beat_q      <= beat_d;
         line_base_q <= line_base_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         off_q       <= off_d;
      end
   end

   // Next-state logic: request acceptance, beat sequencing and read capture.
   // NOTE: every variable gets its hold value first so no path can leave one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      beat_d      = beat_q;
      line_base_d = line_base_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      off_d       = off_q;

      case (state_q)
         S_IDLE: begin
            if (read_en || write_en) begin
               state_d     = read_en ? S_READ : S_WRITE;
               line_base_d = word_addr & LINE_MASK;
               wdata_d     = writeData;
               cyc_d       = '0;
               beat_d      = '0;
`ifdef SRAM_CRIT_WORD_FIRST_EN
               off_d       = OFF_W'(word_addr) & IDX_MASK;
`else
               off_d       = '0;
`endif
            end
         end
         S_READ, S_WRITE: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d = '0;
               if (beat_q == BEAT_LAST) begin
                  state_d = S_DONE;
               end else begin
                  beat_d = beat_q + OFF_W'(1);
               end
               if (state_q == S_READ) begin
                  rdata_d[word_idx*DATA_W +: DATA_W] = SRAM_DQ;
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pipeline freeze: busy, or a request about to be accepted from IDLE.
   always_comb begin
      ready = 1'b1;
      if (busy) begin
         ready = 1'b0;
      end else if ((state_q == S_IDLE) && (read_en || write_en)) begin
         ready = 1'b0;
      end
   end

endmodule
